// File: rtl/mode_register.sv
// mode_register: WIDTH-bit hold/load/shift/rotate/inc/dec register with carry and zero flags.
// Define MODE_REGISTER_SAT_EN to saturate INC/DEC at the range limits instead of wrapping.
module mode_register #(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] Q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             co,
    output logic             zero
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             co_q, co_d;

    // Returns {carry, next value}; the carry is the extra bit of a WIDTH+1-bit sum.
    function automatic logic [WIDTH:0] inc_op(input logic [WIDTH-1:0] q);
        logic [WIDTH:0] sum;
        sum = {1'b0, q} + (WIDTH + 1)'(1);
`ifdef MODE_REGISTER_SAT_EN
        if (sum[WIDTH]) begin
            sum = {1'b1, {WIDTH{1'b1}}};
        end
`endif
        return sum;
    endfunction

    // Returns {borrow, next value}; borrow appears as the top bit of 0 - 1.
    function automatic logic [WIDTH:0] dec_op(input logic [WIDTH-1:0] q);
        logic [WIDTH:0] diff;
        diff = {1'b0, q} - (WIDTH + 1)'(1);
`ifdef MODE_REGISTER_SAT_EN
        if (diff[WIDTH]) begin
            diff = {1'b1, {WIDTH{1'b0}}};
        end
`endif
        return diff;
    endfunction

    always_comb begin
        q_d  = q_q;
        co_d = co_q;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                    q_d  = q_q;
                    co_d = co_q;
                end
                MODE_LOAD: begin
                    q_d  = D;
                    co_d = 1'b0;
                end
                MODE_SHL: begin
                    q_d  = {q_q[WIDTH-2:0], sin_r};
                    co_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d  = {sin_l, q_q[WIDTH-1:1]};
                    co_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    co_d = q_q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_d  = {q_q[0], q_q[WIDTH-1:1]};
                    co_d = q_q[0];
                end
                MODE_INC: {co_d, q_d} = inc_op(q_q);
                MODE_DEC: {co_d, q_d} = dec_op(q_q);
                default: begin
                    q_d  = q_q;
                    co_d = co_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q_q  <= RESET_VAL;
            co_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            co_q <= co_d;
        end
    end

    assign Q      = q_q;
    assign co     = co_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign zero   = (q_q == '0);

endmodule

// File: tb/tb_mode_register.sv
// Self-checking bench for mode_register: directed boundary scenarios plus randomized
// operation sequences compared against an integer-arithmetic reference model.
module tb_mode_register;

    localparam int     W    = 8;
    localparam longint M    = 256;
    localparam longint HALF = 128;
`ifdef MODE_REGISTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] D;
    logic         sin_l, sin_r;
    logic [W-1:0] Q, Q2;
    logic         sout_l, sout_r, co, zero;
    logic         sout_l2, sout_r2, co2, zero2;

    int tests = 0;
    int fails = 0;

    longint mq;
    logic   mco;

    mode_register #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .CLK(CLK), .RST(RST), .en(en), .mode(mode), .D(D), .sin_l(sin_l), .sin_r(sin_r),
        .Q(Q), .sout_l(sout_l), .sout_r(sout_r), .co(co), .zero(zero)
    );

    mode_register #(.WIDTH(W), .RESET_VAL(8'hA5)) dut_rv (
        .CLK(CLK), .RST(RST), .en(en), .mode(mode), .D(D), .sin_l(sin_l), .sin_r(sin_r),
        .Q(Q2), .sout_l(sout_l2), .sout_r(sout_r2), .co(co2), .zero(zero2)
    );

    always #5 CLK = ~CLK;

    // Reference model: register value as an integer in [0, M).
    task automatic ref_step(input logic [2:0] m, input logic [W-1:0] d, input logic sl, input logic sr);
        longint q;
        q = mq;
        case (m)
            3'd0: ;
            3'd1: begin mq = longint'(d); mco = 1'b0; end
            3'd2: begin mco = (q >= HALF); mq = (q * 2) % M + (sr ? 1 : 0); end
            3'd3: begin mco = (q % 2 == 1); mq = q / 2 + (sl ? HALF : 0); end
            3'd4: begin mco = (q >= HALF); mq = (q * 2) % M + ((q >= HALF) ? 1 : 0); end
            3'd5: begin mco = (q % 2 == 1); mq = q / 2 + (q % 2) * HALF; end
            3'd6: begin
                if (q == M - 1) begin mco = 1'b1; mq = SAT ? q : 0; end
                else begin mco = 1'b0; mq = q + 1; end
            end
            default: begin
                if (q == 0) begin mco = 1'b1; mq = SAT ? 0 : M - 1; end
                else begin mco = 1'b0; mq = q - 1; end
            end
        endcase
    endtask

    task automatic cycle(input logic e, input logic [2:0] m, input logic [W-1:0] d,
                         input logic sl, input logic sr);
        en = e; mode = m; D = d; sin_l = sl; sin_r = sr;
        if (e) ref_step(m, d, sl, sr);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0; en = 1'b0; mode = 3'd0; D = '0; sin_l = 1'b0; sin_r = 1'b0;
        mq = 0; mco = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        tests++; if (Q !== 8'h00 || co !== 1'b0 || zero !== 1'b1) begin
            fails++; $display("FAIL reset_initial: Q=%h co=%b zero=%b required Q=00 co=0 zero=1", Q, co, zero);
        end
        tests++; if (Q2 !== 8'hA5 || co2 !== 1'b0) begin
            fails++; $display("FAIL reset_val_initial: Q=%h co=%b required Q=a5 co=0", Q2, co2);
        end
        #2 RST = 1'b1;
        cycle(1'b1, 3'd1, 8'h5A, 1'b0, 1'b0);
        tests++; if (Q !== 8'h5A || Q2 !== 8'h5A) begin
            fails++; $display("FAIL load_5a: Q=%h Q2=%h required 5a", Q, Q2);
        end
        // Assert reset mid-cycle and check before the next edge.
        #2 RST = 1'b0;
        #1;
        tests++; if (Q !== 8'h00 || co !== 1'b0 || zero !== 1'b1) begin
            fails++; $display("FAIL async_reset: Q=%h co=%b zero=%b required Q=00 co=0 zero=1", Q, co, zero);
        end
        tests++; if (Q2 !== 8'hA5) begin
            fails++; $display("FAIL async_reset_val: Q=%h required a5", Q2);
        end
        en = 1'b1; mode = 3'd1; D = 8'h77;
        @(posedge CLK);
        #1;
        tests++; if (Q !== 8'h00 || Q2 !== 8'hA5) begin
            fails++; $display("FAIL reset_held_edge: Q=%h Q2=%h required 00 / a5", Q, Q2);
        end
        #2 RST = 1'b1;
        mq = 0; mco = 1'b0;
        en = 1'b0;
        #2;
    endtask

    task automatic test_load_hold();
        cycle(1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
        tests++; if (Q !== 8'h3C || co !== 1'b0 || zero !== 1'b0) begin
            fails++; $display("FAIL load_3c: Q=%h co=%b zero=%b required Q=3c co=0 zero=0", Q, co, zero);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
        tests++; if (Q !== 8'h3C || co !== 1'b0) begin
            fails++; $display("FAIL hold_en0: Q=%h co=%b required Q=3c co=0", Q, co);
        end
    endtask

    task automatic test_shift();
        cycle(1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
        tests++; if (Q !== 8'h02 || co !== 1'b1) begin
            fails++; $display("FAIL shl: Q=%h co=%b required Q=02 co=1", Q, co);
        end
        cycle(1'b1, 3'd3, 8'h00, 1'b1, 1'b0);
        tests++; if (Q !== 8'h81 || co !== 1'b0 || sout_l !== 1'b1 || sout_r !== 1'b1) begin
            fails++; $display("FAIL shr: Q=%h co=%b sout_l=%b sout_r=%b required Q=81 co=0 1 1", Q, co, sout_l, sout_r);
        end
    endtask

    task automatic test_rotate();
        cycle(1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
        cycle(1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        tests++; if (Q !== 8'h03 || co !== 1'b1) begin
            fails++; $display("FAIL rol: Q=%h co=%b required Q=03 co=1", Q, co);
        end
        cycle(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
        tests++; if (Q !== 8'hC0 || co !== 1'b1) begin
            fails++; $display("FAIL ror2: Q=%h co=%b required Q=c0 co=1", Q, co);
        end
    endtask

    task automatic test_inc_boundary();
        logic [W-1:0] exp_q;
        cycle(1'b1, 3'd1, 8'hFE, 1'b0, 1'b0);
        cycle(1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        tests++; if (Q !== 8'hFF || co !== 1'b0) begin
            fails++; $display("FAIL inc_fe: Q=%h co=%b required Q=ff co=0", Q, co);
        end
        cycle(1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        exp_q = SAT ? 8'hFF : 8'h00;
        tests++; if (Q !== exp_q || co !== 1'b1 || zero !== (exp_q == 8'h00)) begin
            fails++; $display("FAIL inc_ff: Q=%h co=%b zero=%b required Q=%h co=1", Q, co, zero, exp_q);
        end
    endtask

    task automatic test_dec_boundary();
        logic [W-1:0] exp_q;
        cycle(1'b1, 3'd1, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        tests++; if (Q !== 8'h00 || co !== 1'b0 || zero !== 1'b1) begin
            fails++; $display("FAIL dec_01: Q=%h co=%b zero=%b required Q=00 co=0 zero=1", Q, co, zero);
        end
        cycle(1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        exp_q = SAT ? 8'h00 : 8'hFF;
        tests++; if (Q !== exp_q || co !== 1'b1) begin
            fails++; $display("FAIL dec_00: Q=%h co=%b required Q=%h co=1", Q, co, exp_q);
        end
    endtask

    task automatic test_random();
        logic [2:0]   m;
        logic [W-1:0] d;
        logic         e;
        for (int i = 0; i < 300; i++) begin
            e = ($urandom_range(0, 4) != 0);
            m = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00)
                                             : 8'($urandom_range(0, 255));
            cycle(e, m, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tests++;
            if (Q !== mq[W-1:0] || co !== mco || zero !== (mq == 0) ||
                sout_l !== (mq >= HALF) || sout_r !== (mq % 2 == 1)) begin
                fails++;
                $display("FAIL random[%0d] en=%b mode=%0d: Q=%h co=%b zero=%b required Q=%h co=%b",
                         i, e, m, Q, co, zero, mq[W-1:0], mco);
            end
        end
    endtask

    task automatic test_reset_during_op();
        cycle(1'b1, 3'd1, 8'h5A, 1'b0, 1'b0);
        en = 1'b1; mode = 3'd6;
        #2 RST = 1'b0;
        #1;
        tests++; if (Q !== 8'h00 || co !== 1'b0 || Q2 !== 8'hA5) begin
            fails++; $display("FAIL reset_during_inc: Q=%h co=%b Q2=%h required 00 0 a5", Q, co, Q2);
        end
        @(posedge CLK);
        #3 RST = 1'b1;
        mq = 0; mco = 1'b0;
        #1;
        cycle(1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        tests++; if (Q !== 8'h01 || co !== 1'b0) begin
            fails++; $display("FAIL inc_after_reset: Q=%h co=%b required Q=01 co=0", Q, co);
        end
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_shift();
        test_rotate();
        test_inc_boundary();
        test_dec_boundary();
        test_random();
        test_reset_during_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
